seq_addsub_unit: RTL and testbench
==================================

// Module: seq_addsub_unit
//
// PURPOSE
//  Multi-cycle, chunked two's-complement add/subtract unit for the calculator datapath.
//  - Processes CHUNK bits per clock through an internal ripple slice, so wide operands
//    (up to 32-bit) fit the DE10-Lite without a long combinational carry chain.
//  - Sits between the operand registers and the result/display logic.
//  - Adds the following over a plain combinational adder:
//    - start/busy/done handshake;
//    - built-in subtract mode;
//    - carry, signed overflow and zero flags.
//
// PARAMETERS
//  N      8   operand/result width in bits; must be a multiple of CHUNK
//  CHUNK  4   bits computed per RUN cycle; NCH = N/CHUNK is the chunk count
//
// PORTS
//  clk    in   1  rising-edge clock
//  reset  in   1  asynchronous, active-high reset
//  start  in   1  request an operation; sampled on clk; accepted only in IDLE or DONE
//  sub    in   1  0: a+b+cin   1: a-b (cin ignored)
//  a      in   N  operand A, captured when start is accepted
//  b      in   N  operand B, captured when start is accepted
//  cin    in   1  carry-in for add mode
//  busy   out  1  high while state==RUN
//  done   out  1  one-cycle pulse; sum and flags valid from this cycle on
//  sum    out  N  result, held until next completion
//  cout   out  1  final carry; in sub mode 1 = no borrow
//  ovf    out  1  signed overflow = carry into MSB XOR carry out of MSB
//  zero   out  1  sum == 0
//
// BEHAVIOUR
//  - Reset (asynchronous, any state):
//    - state=IDLE; busy=0, done=0;
//    - sum=0, cout=0, ovf=0, zero=0;
//    - internal operand/partial registers cleared.
//  - FSM states IDLE -> RUN -> DONE -> IDLE.
//    - IDLE/DONE, start=1: capture A=a, B=b^{N{sub}}, carry=sub?1:cin, chunk index=0;
//      go to RUN. If start=0 in DONE, go to IDLE.
//    - RUN: each cycle adds chunk [i*CHUNK +: CHUNK] of A and B plus carry, stores that
//      partial sum chunk and the new carry, then i++. The MSB-chunk cycle also records
//      the carry into bit N-1.
//    - RUN, i==NCH-1: at that edge, load sum/cout/ovf/zero from the completed result,
//      done<=1, go to DONE.
//    - DONE lasts exactly one cycle; done=1 only in DONE.
//  - Timing:
//    - Latency: start accepted at edge k -> done high in the cycle after edge k+NCH.
//    - Back-to-back ops are possible via start in DONE. Throughput is one op per NCH+1
//      cycles.
//  - start while busy is ignored. Operand changes during RUN have no effect.
//  - sum and flags change only at completion; they never show partial results.
//  - Flags:
//    - ovf uses signed interpretation of A and effective B.
//    - cout is the raw carry out (for a-b: 1 when a>=b unsigned).
//    - zero is computed on the final driven sum.
//  - CHUNK==N degenerates to one RUN cycle, done 2 cycles after start. CHUNK==1 is
//    bit-serial.
//  - sub=1, b=0: effective B=all ones + carry 1 -> sum=a, cout=1.
//
// CONFIGURATION
//  ADDSUB_SAT_EN
//  - Defined: when ovf=1, sum saturates:
//    - a[N-1]==0 -> {0,{N-1{1}}} (positive max);
//    - else {1,{N-1{0}}} (negative min).
//    - cout and ovf are still the raw values; zero is evaluated on the saturated sum.
//  - Undefined: sum is always the wrapped N-bit result and no saturation logic is built.
//
// TESTING  (N=8, CHUNK=4 unless stated)
//  - a=4, b=3, sub=0, cin=0, start at edge k
//    -> done only in cycle after k+2; sum=7, cout=0, ovf=0, zero=0; busy high 2 cycles.
//  - a=4, b=3, sub=1 -> sum=1, cout=1, ovf=0.
//    a=3, b=4, sub=1 -> sum=8'hFF, cout=0, ovf=0.
//  - a=8'hFF, b=8'h01, cin=0 -> sum=0, cout=1, zero=1.
//    a=8'hFF, b=0, cin=1 -> same result.
//  - a=100, b=100, sub=0 -> ovf=1, cout=0;
//    sum=8'hC8 without ADDSUB_SAT_EN, 8'h7F with it.
//    a=8'h80, b=1, sub=1 -> ovf=1; sum=8'h7F without, 8'h80 with.
//  - Handshake and reset:
//    - pulse start again during RUN -> ignored, single done;
//    - start held in DONE -> back-to-back op, next done NCH+1 cycles later;
//    - reset asserted mid-RUN -> all outputs 0 immediately, no done.
//  - Re-parameterise N=16 with CHUNK=16 and CHUNK=1 on random vectors vs a+b+cin/a-b
//    -> results match; done latency 2 and 17 cycles.

Source files
------------

// File: rtl/seq_addsub_unit.sv
// Chunked two's-complement add/subtract unit (CHUNK bits per cycle) with carry/ovf/zero flags.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+N/CHUNK.
// Backpressure: start is ignored while busy; build option ADDSUB_SAT_EN saturates sum on overflow.
module seq_addsub_unit #(
  parameter int N     = 8,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int NCH = N / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);
  localparam logic [N-1:0] POS_MAX = {N{1'b1}} >> 1;
  localparam logic [N-1:0] NEG_MIN = ~POS_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  // Operands are shifted right each RUN cycle so the live chunk is always in the low bits.
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic            carry;
  logic [IW-1:0]   idx;
  // Partial result fills from the top; after NCH cycles chunk 0 sits at the LSBs.
  logic [N-1:0]    part;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] s;
  logic             c_out;
  logic             c_msb;
  logic             res_ovf;
  logic [N-1:0]     raw;
  logic [N-1:0]     fin;

  // Ripple slice for the current chunk, plus completed-result and flag formation.
  always_comb begin
    ca         = op_a[CHUNK-1:0];
    cb         = op_b[CHUNK-1:0];
    {c_out, s} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
    // Carry into the top bit of this chunk recovered from the sum bit; only used on the MSB chunk.
    c_msb      = s[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
    res_ovf    = c_msb ^ c_out;
    raw        = (part >> CHUNK) | (N'(s) << (N - CHUNK));
    fin        = raw;
`ifdef ADDSUB_SAT_EN
    // On the last chunk ca[CHUNK-1] is the sign bit of operand A.
    if (res_ovf) begin
      fin = ca[CHUNK-1] ? NEG_MIN : POS_MAX;
    end
`endif
  end

  // Control FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      part  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b ^ {N{sub}};
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            part  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          op_a  <= op_a >> CHUNK;
          op_b  <= op_b >> CHUNK;
          carry <= c_out;
          part  <= raw;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            sum   <= fin;
            cout  <= c_out;
            ovf   <= res_ovf;
            zero  <= (fin == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef ADDSUB_SAT_EN
  // Saturation constants are only consumed when saturation is built in.
  logic unused_sat;
  assign unused_sat = ^{POS_MAX, NEG_MIN};
`endif

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Self-checking bench for seq_addsub_unit: 8/4 directed + random, plus 16-bit CHUNK=16 and CHUNK=1.
// Expected results come from an integer reference model of add/subtract with flags.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_addsub_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy_w, done_w, cout_w, ovf_w, zero_w;
  logic [15:0] sum_w;
  logic        busy_s, done_s, cout_s, ovf_s, zero_s;
  logic [15:0] sum_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_addsub_unit #(.N(8), .CHUNK(4)) dut (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  seq_addsub_unit #(.N(16), .CHUNK(16)) dut_wide (
    .clk(clk), .reset(reset), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy_w), .done(done_w), .sum(sum_w), .cout(cout_w), .ovf(ovf_w), .zero(zero_w)
  );

  seq_addsub_unit #(.N(16), .CHUNK(1)) dut_serial (
    .clk(clk), .reset(reset), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy_s), .done(done_s), .sum(sum_s), .cout(cout_s), .ovf(ovf_s), .zero(zero_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Integer model: true signed sum decides overflow, unsigned sum gives carry and wrapped result.
  function automatic void ref_op(input int w, input longint ua, input longint ub, input bit sv,
                                 input bit cv, output longint s, output bit co, output bit ov,
                                 output bit z);
    longint m, half, u, sa, sb, t;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    u    = ua + (sv ? ((~ub) & m) : ub) + (sv ? 1 : longint'(cv));
    co   = ((u >> w) & 1) != 0;
    s    = u & m;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    t    = sv ? (sa - sb) : (sa + sb + longint'(cv));
    ov   = (t >= half) || (t < -half);
`ifdef ADDSUB_SAT_EN
    if (ov) s = (sa < 0) ? half : half - 1;
`endif
    z    = (s == 0);
  endfunction

  // One 8-bit op; operands are scrambled during RUN to show they are not re-sampled.
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input bit sv, input bit cv);
    longint es;
    bit eco, eov, ez;
    int lat, bc;
    ref_op(8, longint'(av), longint'(bv), sv, cv, es, eco, eov, ez);
    @(negedge clk);
    a8 = av; b8 = bv; sub8 = sv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    lat = 1; bc = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bc++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 3);
    check({tag, " busy_cycles"}, bc, 2);
    check({tag, " sum"}, sum8, es);
    check({tag, " cout"}, cout8, eco);
    check({tag, " ovf"}, ovf8, eov);
    check({tag, " zero"}, zero8, ez);
  endtask

  // One op on both 16-bit instances started in the same cycle.
  task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input bit sv, input bit cv);
    longint es;
    bit eco, eov, ez, got_w, got_s;
    int lat;
    ref_op(16, longint'(av), longint'(bv), sv, cv, es, eco, eov, ez);
    @(negedge clk);
    a16 = av; b16 = bv; sub16 = sv; cin16 = cv; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 1; got_w = 1'b0; got_s = 1'b0;
    while (!(got_w && got_s) && lat < 40) begin
      if (done_w && !got_w) begin
        got_w = 1'b1;
        check({tag, " c16 latency"}, lat, 2);
        check({tag, " c16 sum"}, sum_w, es);
        check({tag, " c16 cout"}, cout_w, eco);
        check({tag, " c16 ovf"}, ovf_w, eov);
        check({tag, " c16 zero"}, zero_w, ez);
      end
      if (done_s && !got_s) begin
        got_s = 1'b1;
        check({tag, " c1 latency"}, lat, 17);
        check({tag, " c1 sum"}, sum_s, es);
        check({tag, " c1 cout"}, cout_s, eco);
        check({tag, " c1 ovf"}, ovf_s, eov);
        check({tag, " c1 zero"}, zero_s, ez);
      end
      if (!(got_w && got_s)) begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, " c16 done_seen"}, got_w, 1);
    check({tag, " c1 done_seen"}, got_s, 1);
  endtask

  initial begin
    int ndone;
    int lat;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst sum", sum8, 0);
    check("rst cout", cout8, 0);
    check("rst ovf", ovf8, 0);
    check("rst zero", zero8, 0);
    check("rst sum16", sum_s, 0);
    reset = 1'b0;

    // Directed 8-bit cases
    run8("add_4_3", 8'd4, 8'd3, 1'b0, 1'b0);
    check("add_4_3 const", sum8, 8'd7);
    run8("sub_4_3", 8'd4, 8'd3, 1'b1, 1'b0);
    check("sub_4_3 const", {cout8, sum8}, 9'h101);
    run8("sub_3_4", 8'd3, 8'd4, 1'b1, 1'b0);
    check("sub_3_4 const", {cout8, ovf8, sum8}, 10'h0FF);
    run8("add_ff_1", 8'hFF, 8'h01, 1'b0, 1'b0);
    check("add_ff_1 const", {cout8, zero8, sum8}, 10'h300);
    run8("add_ff_0_cin", 8'hFF, 8'h00, 1'b0, 1'b1);
    run8("add_100_100", 8'd100, 8'd100, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    check("add_100_100 const", {ovf8, cout8, sum8}, 10'h27F);
`else
    check("add_100_100 const", {ovf8, cout8, sum8}, 10'h2C8);
`endif
    run8("sub_80_1", 8'h80, 8'h01, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
    check("sub_80_1 const", {ovf8, sum8}, 9'h180);
`else
    check("sub_80_1 const", {ovf8, sum8}, 9'h17F);
`endif
    run8("sub_b0_cin_ignored", 8'h55, 8'h00, 1'b1, 1'b1);
    check("sub_b0 const", {cout8, sum8}, 9'h155);
    run8("sub_7f_80", 8'h7F, 8'h80, 1'b1, 1'b0);

    // start pulsed during RUN must be ignored
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'd1; b8 = 8'd1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done8) begin
        ndone++;
        check("ignore_start sum", sum8, 8'd30);
      end
      @(negedge clk);
    end
    check("ignore_start done_count", ndone, 1);

    // Back-to-back: start held in the DONE cycle
    run8("b2b_first", 8'd50, 8'd25, 1'b0, 1'b1);
    a8 = 8'd7; b8 = 8'd9; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b done_dropped", done8, 0);
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b latency", lat, 3);
    check("b2b sum", sum8, 8'd16);

    // Reset mid-RUN clears outputs at once and suppresses done
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h20; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("midrun busy_before", busy8, 1);
    reset = 1'b1;
    #1;
    check("midrun busy", busy8, 0);
    check("midrun done", done8, 0);
    check("midrun sum", sum8, 0);
    check("midrun flags", {cout8, ovf8, zero8}, 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done8 || busy8) ndone++;
      @(negedge clk);
    end
    check("midrun no_activity", ndone, 0);

    // Random 8-bit vectors
    for (int i = 0; i < 16; i++) begin
      run8($sformatf("rnd8_%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    // 16-bit width, single-cycle and bit-serial configurations
    run16("w16_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run16("w16_zero", 16'h1234, 16'h1234, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run16($sformatf("rnd16_%0d", i), 16'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
